// File: rtl/pipeline_fd_reg.sv
// rtl/pipeline_fd_reg.sv - IF/ID pipeline register with stall, flush, valid bit and event counters
// Holds the fetch-stage bundle for decode; hazard unit drives StallD/FlushD.

module pipeline_fd_reg #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   NOP      = XLEN'(32'h0000_0013),
   parameter logic [XLEN-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   InstrF,
   input  logic [XLEN-1:0]   PCF,
   input  logic [XLEN-1:0]   PCPlus4F,
   input  logic              ValidF,
   input  logic              StallD,
   input  logic              FlushD,
   input  logic              CntClr,
   output logic [XLEN-1:0]   InstrD,
   output logic [XLEN-1:0]   PCD,
   output logic [XLEN-1:0]   PCPlus4D,
   output logic              ValidD,
   output logic [CNT_W-1:0]  StallCnt,
   output logic [CNT_W-1:0]  FlushCnt
);

   // Reset PC+4 wraps modulo 2^XLEN, so a top-of-space RESET_PC yields zero.
   localparam logic [XLEN-1:0]  RESET_PC4 = RESET_PC + XLEN'(4);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [XLEN-1:0]  instr_d,     instr_q;
   logic [XLEN-1:0]  pc_d,        pc_q;
   logic [XLEN-1:0]  pc_plus4_d,  pc_plus4_q;
   logic             valid_d,     valid_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
   logic             stall_inc;

   // Flush wins over stall so a squashed slot can never re-present its old instruction.
   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (FlushD) begin
         instr_d = NOP;
         valid_d = 1'b0;
      end else if (!StallD) begin
         pc_d       = PCF;
         pc_plus4_d = PCPlus4F;
         valid_d    = ValidF;
         instr_d    = ValidF ? InstrF : NOP;
      end
   end

   // Only stalls that actually freeze a live instruction are worth counting.
   assign stall_inc = StallD && !FlushD && valid_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (CntClr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if (FlushD && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q     <= NOP;
         pc_q        <= RESET_PC;
         pc_plus4_q  <= RESET_PC4;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         pc_plus4_q  <= pc_plus4_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign InstrD   = instr_q;
   assign PCD      = pc_q;
   assign PCPlus4D = pc_plus4_q;
   assign ValidD   = valid_q;
   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;

endmodule
